// File: rtl/elevador_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | elevador_pkg: shared constants for the cabin occupancy display        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package elevador_pkg;

  localparam int CONT_W = 4;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  // Active-low segments, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_DIGITO [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic logic [6:0] seg_digito(input logic [CONT_W-1:0] d);
    logic [6:0] s;
    s = SEG_APAGADO;
    if (d <= CONT_W'(9)) s = SEG_DIGITO[d];
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_sensor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | filtro_sensor: 2-flop sync, debounce and rising-edge event pulse      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module filtro_sensor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_i,
  output logic evento_o
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sinc1_q, sinc2_q;
  logic [1:0]       valido_q, valido_d;
  logic             nivel_q, nivel_d, nivel_ant_q;
  logic             pulso_q, pulso_d;
  logic             armado_q, armado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, arm_cnt_q, arm_cnt_d;

  always_comb begin
    nivel_d   = nivel_q;
    cnt_d     = '0;
    armado_d  = armado_q;
    arm_cnt_d = arm_cnt_q;
    valido_d  = {valido_q[0], 1'b1};
    pulso_d   = nivel_q & ~nivel_ant_q & armado_q;

    if (sinc2_q != nivel_q) begin
      if (cnt_q == CNT_FIM) nivel_d = ~nivel_q;
      else                  cnt_d   = cnt_q + CNT_W'(1);
    end

    // Edges only count once the line has been seen genuinely low after reset,
    // so a beam still blocked across a reset is not counted as a new person.
    if (!armado_q && valido_q[1]) begin
      if (sinc2_q)                    arm_cnt_d = '0;
      else if (arm_cnt_q == CNT_FIM)  armado_d  = 1'b1;
      else                            arm_cnt_d = arm_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q     <= 1'b0;
      sinc2_q     <= 1'b0;
      valido_q    <= '0;
      nivel_q     <= 1'b0;
      nivel_ant_q <= 1'b0;
      pulso_q     <= 1'b0;
      armado_q    <= 1'b0;
      cnt_q       <= '0;
      arm_cnt_q   <= '0;
    end else begin
      sinc1_q     <= sensor_i;
      sinc2_q     <= sinc1_q;
      valido_q    <= valido_d;
      nivel_q     <= nivel_d;
      nivel_ant_q <= nivel_q;
      pulso_q     <= pulso_d;
      armado_q    <= armado_d;
      cnt_q       <= cnt_d;
      arm_cnt_q   <= arm_cnt_d;
    end
  end

  assign evento_o = pulso_q;

endmodule
`default_nettype wire

// File: rtl/display_ocupacao.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | display_ocupacao: cabin occupancy counter with capacity/overload flags|
// | and a blinking active-low 7-segment digit. Revision: 1.0              |
// +----------------------------------------------------------------------+
module display_ocupacao
  import elevador_pkg::*;
#(
  parameter int MAX_PESSOAS     = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_CYCLES    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sensor_entrada,
  input  logic              sensor_saida,
  input  logic              porta_aberta,
  input  logic              zerar,
  output logic [CONT_W-1:0] contagem,
  output logic              lotado,
  output logic              excesso,
  output logic [6:0]        seg
);

  localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(MAX_PESSOAS);
  localparam int                BLK_W    = $clog2(BLINK_CYCLES);
  localparam logic [BLK_W-1:0]  BLK_FIM  = BLK_W'(BLINK_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_MEIO = BLK_W'(BLINK_CYCLES / 2);

  logic              ev_entrada, ev_saida;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic              lot_q, lot_d;
  logic              exc_q, exc_d;
  logic [BLK_W-1:0]  pisca_q, pisca_d;
  logic [6:0]        seg_q, seg_d;

  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_entrada (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_i (sensor_entrada),
    .evento_o (ev_entrada)
  );

  filtro_sensor #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_saida (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_i (sensor_saida),
    .evento_o (ev_saida)
  );

  always_comb begin
    cont_d = cont_q;
    exc_d  = exc_q;
    if (zerar) begin
      cont_d = '0;
      exc_d  = 1'b0;
    end else if (porta_aberta) begin
      if (ev_entrada && !ev_saida) begin
        if (cont_q >= CONT_MAX) exc_d  = 1'b1;
        else                    cont_d = cont_q + CONT_W'(1);
      end else if (ev_saida && !ev_entrada && cont_q != '0) begin
        cont_d = cont_q - CONT_W'(1);
        exc_d  = 1'b0;
      end
    end
    lot_d = (cont_d == CONT_MAX);

    pisca_d = '0;
    if (exc_q) pisca_d = (pisca_q == BLK_FIM) ? '0 : pisca_q + BLK_W'(1);

    seg_d = (exc_q && pisca_q >= BLK_MEIO) ? SEG_APAGADO : seg_digito(cont_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q  <= '0;
      lot_q   <= 1'b0;
      exc_q   <= 1'b0;
      pisca_q <= '0;
      seg_q   <= SEG_DIGITO[0];
    end else begin
      cont_q  <= cont_d;
      lot_q   <= lot_d;
      exc_q   <= exc_d;
      pisca_q <= pisca_d;
      seg_q   <= seg_d;
    end
  end

  assign contagem = cont_q;
  assign lotado   = lot_q;
  assign excesso  = exc_q;
  assign seg      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_display_ocupacao.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_ocupacao: randomized and directed bench with a reference  |
// | model of the occupancy display. Revision: 1.0                         |
// +----------------------------------------------------------------------+
module tb_display_ocupacao;

  localparam int D    = 2;
  localparam int MAXP = 3;
  localparam int B    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_ent = 1'b0, s_sai = 1'b0, porta = 1'b0, zerar = 1'b0;
  logic [3:0] contagem;
  logic       lotado, excesso;
  logic [6:0] seg;

  int n_tests = 0;
  int n_fail  = 0;

  display_ocupacao #(.MAX_PESSOAS(MAXP), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_entrada (s_ent),
    .sensor_saida   (s_sai),
    .porta_aberta   (porta),
    .zerar          (zerar),
    .contagem       (contagem),
    .lotado         (lotado),
    .excesso        (excesso),
    .seg            (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic pulso(input int t, input int ini, input int len);
    return (t >= ini) && (t < ini + len);
  endfunction

  // Reference model: raw samples flow through a 2-edge delay (-1 = nothing
  // sampled since reset), a level is accepted after D differing samples, and
  // an accepted rise is applied to the count two edges later.
  int         m_d1[2], m_d2[2], m_run[2], m_low[2];
  bit         m_lvl[2], m_arm[2], m_rise[2], m_ev[2];
  int         m_cnt, m_blink;
  bit         m_exc, m_lot;
  logic [6:0] m_seg;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_d1[i] = -1; m_d2[i] = -1; m_run[i] = 0; m_low[i] = 0;
      m_lvl[i] = 0; m_arm[i] = 0; m_rise[i] = 0; m_ev[i] = 0;
    end
    m_cnt = 0; m_exc = 0; m_lot = 0; m_blink = 0; m_seg = digit(0);
  endtask

  task automatic model_step();
    bit ev[2];
    int raw[2];
    raw[0] = int'(s_ent);
    raw[1] = int'(s_sai);
    m_seg   = (m_exc && (m_blink % B) >= B / 2) ? 7'b1111111 : digit(m_cnt);
    m_blink = m_exc ? m_blink + 1 : 0;
    for (int i = 0; i < 2; i++) begin
      ev[i]     = m_ev[i];
      m_ev[i]   = m_rise[i];
      m_rise[i] = 0;
      if (!m_arm[i] && m_d2[i] >= 0) begin
        if (m_d2[i] == 0) begin
          m_low[i]++;
          if (m_low[i] >= D) m_arm[i] = 1;
        end else m_low[i] = 0;
      end
      if ((m_d2[i] == 1) == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i]  = !m_lvl[i];
          m_run[i]  = 0;
          m_rise[i] = m_lvl[i] && m_arm[i];
        end
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = raw[i];
    end
    if (zerar) begin
      m_cnt = 0; m_exc = 0;
    end else if (porta) begin
      if (ev[0] && !ev[1]) begin
        if (m_cnt < MAXP) m_cnt++;
        else m_exc = 1;
      end else if (ev[1] && !ev[0] && m_cnt > 0) begin
        m_cnt--; m_exc = 0;
      end
    end
    m_lot = (m_cnt == MAXP);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic test_reset();
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'd0, 1'b0, 1'b0, 7'b0000001}) begin
        n_fail++;
        $display("FAIL reset t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected 0 0 0 0000001", t, contagem, lotado, excesso, seg);
      end
      if (t == 3) rst_n = 1'b1;
    end
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
    end
    porta = 1'b1;
  endtask

  task automatic test_latency();
    s_ent = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_tests++;
      if (contagem !== ((j >= 5) ? 4'd1 : 4'd0)) begin
        n_fail++;
        $display("FAIL latency_cnt edge k+%0d: cnt=%0d, expected %0d", j, contagem, (j >= 5) ? 1 : 0);
      end
      n_tests++;
      if (seg !== ((j >= 6) ? 7'b1001111 : 7'b0000001)) begin
        n_fail++;
        $display("FAIL latency_seg edge k+%0d: seg=%b, expected %b", j, seg, (j >= 6) ? 7'b1001111 : 7'b0000001);
      end
      if (j == 5) s_ent = 1'b0;
    end
  endtask

  task automatic test_glitch();
    int base;
    logic [9:0] bounce;
    base   = m_cnt;
    bounce = 10'b1111110101;
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL glitch t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      if (t == 12) begin
        n_tests++;
        if (contagem !== 4'(base)) begin
          n_fail++;
          $display("FAIL glitch_isolated: cnt=%0d, expected %0d", contagem, base);
        end
      end
      s_ent = (t == 2) || (t >= 14 && t < 24 && bounce[t-14]);
    end
    n_tests++;
    if (contagem !== 4'(base + 1)) begin
      n_fail++;
      $display("FAIL glitch_bounce: cnt=%0d, expected %0d", contagem, base + 1);
    end
  endtask

  task automatic test_capacity();
    int blanks;
    blanks = 0;
    zerar  = 1'b1;
    for (int t = 0; t < 72; t++) begin
      @(negedge clk);
      zerar = 1'b0;
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL capacity t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      if (t >= 40 && t < 48 && seg === 7'b1111111) blanks++;
      if (t == 48) begin
        n_tests++;
        if ({contagem, lotado, excesso} !== {4'd3, 1'b1, 1'b1} || blanks != B) begin
          n_fail++;
          $display("FAIL capacity_full: cnt=%0d lot=%b exc=%b blanks=%0d, expected 3 1 1 blanks=%0d", contagem, lotado, excesso, blanks, B);
        end
      end
      s_ent = pulso(t, 0, 4) || pulso(t, 10, 4) || pulso(t, 20, 4) || pulso(t, 30, 4);
      s_sai = pulso(t, 50, 4);
    end
    n_tests++;
    if ({contagem, lotado, excesso, seg} !== {4'd2, 1'b0, 1'b0, 7'b0010010}) begin
      n_fail++;
      $display("FAIL capacity_exit: cnt=%0d lot=%b exc=%b seg=%b, expected 2 0 0 0010010", contagem, lotado, excesso, seg);
    end
  endtask

  task automatic test_exit_floor();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL exit_floor t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      s_sai = pulso(t, 0, 4) || pulso(t, 10, 4) || pulso(t, 20, 4);
    end
    n_tests++;
    if ({contagem, seg} !== {4'd0, 7'b0000001}) begin
      n_fail++;
      $display("FAIL exit_floor_end: cnt=%0d seg=%b, expected 0 0000001", contagem, seg);
    end
  endtask

  task automatic test_simultaneous();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL simultaneous t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      s_ent = pulso(t, 0, 4) || pulso(t, 10, 4) || pulso(t, 25, 5);
      s_sai = pulso(t, 25, 5);
    end
    n_tests++;
    if (contagem !== 4'd2) begin
      n_fail++;
      $display("FAIL simultaneous_end: cnt=%0d, expected 2", contagem);
    end
  endtask

  task automatic test_door_closed();
    int base;
    base  = m_cnt;
    porta = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL door_closed t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      s_ent = pulso(t, 1, 8);
      porta = (t >= 7);
    end
    n_tests++;
    if (contagem !== 4'(base)) begin
      n_fail++;
      $display("FAIL door_closed_end: cnt=%0d, expected %0d", contagem, base);
    end
  endtask

  task automatic test_zerar();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL zerar t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      if (t == 44) begin
        n_tests++;
        if ({contagem, lotado, excesso} !== {4'd3, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL zerar_before: cnt=%0d lot=%b exc=%b, expected 3 1 1", contagem, lotado, excesso);
        end
      end
      s_ent = pulso(t, 0, 4) || pulso(t, 10, 4) || pulso(t, 20, 4);
      zerar = (t == 44);
    end
    n_tests++;
    if ({contagem, lotado, excesso, seg} !== {4'd0, 1'b0, 1'b0, 7'b0000001}) begin
      n_fail++;
      $display("FAIL zerar_after: cnt=%0d lot=%b exc=%b seg=%b, expected 0 0 0 0000001", contagem, lotado, excesso, seg);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL random t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      if ($urandom_range(0, 4) == 0) s_ent = ~s_ent;
      if ($urandom_range(0, 5) == 0) s_sai = ~s_sai;
      if ($urandom_range(0, 30) == 0) porta = ~porta;
      zerar = ($urandom_range(0, 99) == 0);
    end
    s_ent = 1'b0; s_sai = 1'b0; zerar = 1'b0; porta = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    zerar = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      zerar = 1'b0;
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL reset_pre t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      s_ent = pulso(t, 2, 4) || (t >= 16);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({contagem, lotado, excesso, seg} !== {4'd0, 1'b0, 1'b0, 7'b0000001}) begin
      n_fail++;
      $display("FAIL reset_async: cnt=%0d lot=%b exc=%b seg=%b, expected 0 0 0 0000001", contagem, lotado, excesso, seg);
    end
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      n_tests++;
      if ({contagem, lotado, excesso, seg} !== {4'(m_cnt), m_lot, m_exc, m_seg}) begin
        n_fail++;
        $display("FAIL reset_post t=%0d: cnt=%0d lot=%b exc=%b seg=%b, expected cnt=%0d lot=%b exc=%b seg=%b", t, contagem, lotado, excesso, seg, m_cnt, m_lot, m_exc, m_seg);
      end
      if (t == 14) begin
        n_tests++;
        if (contagem !== 4'd0) begin
          n_fail++;
          $display("FAIL reset_held_sensor: cnt=%0d, expected 0", contagem);
        end
      end
      if (t == 1) rst_n = 1'b1;
      s_ent = (t < 14) || pulso(t, 22, 4);
    end
    n_tests++;
    if (contagem !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_rearm: cnt=%0d, expected 1", contagem);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_capacity();
    test_exit_floor();
    test_simultaneous();
    test_door_closed();
    test_zerar();
    test_random();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_ocupacao.md
Name: display_ocupacao

Overview:
- Parametrised successor to the 2-bit passenger display.
- Counts passengers in the car from two door sensors (entry/exit), enforces capacity, flags overload attempts, and drives one active-low 7-segment digit showing the occupancy.
- Sits between the car-door sensor pins and the cabin display.
- Takes its enable from the door controller.

Parameters:
- MAX_PESSOAS, 6, car capacity; legal range 1..9.
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples needed to accept a new sensor level; must be >= 1.
- BLINK_CYCLES, 8, full blink period in clocks while overload is flagged; even, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sensor_entrada  in  1  raw entry beam sensor (asynchronous, bouncy); a high pulse means one person entered.
- sensor_saida  in  1  raw exit beam sensor; a high pulse means one person left.
- porta_aberta  in  1  counting enable, synchronous to clk; events are discarded while low.
- zerar  in  1  synchronous clear of count and flags.
- contagem  out  4  current occupancy, 0..MAX_PESSOAS.
- lotado  out  1  high when contagem == MAX_PESSOAS.
- excesso  out  1  sticky overload-attempt flag.
- seg  out  7  segments, active-low; seg[6]=a … seg[0]=g.

Behaviour:
- Reset values (async assert, sync deassert):
  - contagem=0, lotado=0, excesso=0.
  - seg=7'b0000001, which is digit "0".
  - Synchroniser flops, debounced levels, debounce counters and blink counter all reset to 0.
- Sensor path (per sensor, identical):
  - 2-flop synchroniser.
  - Debounce counter resets whenever the synchronised sample equals the current debounced level.
  - When DEBOUNCE_CYCLES consecutive samples differ from the debounced level, the debounced level toggles.
  - Event = 1-cycle pulse on a debounced rising edge; a falling edge generates nothing.
- Latency:
  - A clean input step captured at edge k appears on contagem at edge k+DEBOUNCE_CYCLES+3.
  - seg follows one edge after contagem.
  - Glitches shorter than DEBOUNCE_CYCLES clocks produce no event.
- Update rules, in priority order per cycle:
  - zerar=1: contagem=0, excesso=0. Events that cycle are discarded.
  - porta_aberta=0: events discarded. Debouncing and edge tracking continue, so a pulse that started while closed is never counted late.
  - Entry and exit events in the same cycle: contagem unchanged, excesso unchanged.
  - Entry only, contagem < MAX_PESSOAS: contagem+1.
  - Entry only, contagem == MAX_PESSOAS: contagem held, excesso set.
  - Exit only, contagem > 0: contagem-1, and excesso cleared.
  - Exit only, contagem == 0: ignored; no wrap-around.
- lotado is registered and derived from the next-state contagem, so it changes on the same edge as contagem.
- Display:
  - seg is registered from contagem via the digit table (one-cycle latency).
  - While excesso=1, the blink counter runs modulo BLINK_CYCLES:
    - first half of the period: seg shows the digit;
    - second half: seg=7'b1111111 (blank).
  - When excesso clears, the blink counter resets to 0 and the digit shows steadily from the next edge.
- Reset asserted mid-pulse: all state clears immediately. A sensor still high after release must first read low for DEBOUNCE_CYCLES before another rising edge can count.

Decomposition:
- Package elevador_pkg:
  - SEG_DIGITO[0:9] active-low 7-bit constants;
  - SEG_APAGADO = 7'b1111111;
  - contagem width constant CONT_W=4.
- Sub-module filtro_sensor (synchroniser + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.
- Top holds the counter, flags, blink timer and segment register.

Test Plan (DEBOUNCE_CYCLES=2, MAX_PESSOAS=3, BLINK_CYCLES=4):
- Reset, then idle → contagem=0, lotado=0, excesso=0, seg=0000001.
- porta_aberta=1, one clean 6-cycle entry pulse captured at edge k → contagem=1 at edge k+5; seg=1001111 at edge k+6.
- Entry pulse with 1-cycle bounce glitches before settling → exactly one increment. Isolated 1-cycle glitch → no change.
- Four entry pulses → contagem 1,2,3,3; lotado=1 after the third. Fourth pulse sets excesso=1 and seg alternates "3" (0000110) / 1111111 every 2 clocks. One exit pulse → contagem=2, lotado=0, excesso=0, steady 0010010.
- Exit pulse at contagem=0 → stays 0. Entry and exit debounced edges in the same cycle at contagem=2 → stays 2.
- porta_aberta=0 during an entry pulse → no count, even if porta_aberta rises before the pulse ends. zerar at contagem=3 with excesso=1 → contagem=0, flags 0. rst_n low mid-pulse → all outputs at reset values asynchronously.
